// File: rtl/lbdr_pkg.sv
// lbdr_pkg: flit_id encodings, flit field geometry and packet FSM state shared by the input FIFO slice
package lbdr_pkg;
   localparam logic [2:0] HEADER  = 3'b001;
   localparam logic [2:0] PAYLOAD = 3'b010;
   localparam logic [2:0] TAIL    = 3'b100;
   localparam int ID_W   = 3;
   localparam int ADDR_W = 4;
   typedef enum logic {IDLE, IN_PKT} pkt_state_t;
endpackage

// File: rtl/lbdr_pkt_checker.sv
// lbdr_pkt_checker: write-side packet framing FSM; only flits that continue a legal HEADER..TAIL sequence are stored
module lbdr_pkt_checker
   import lbdr_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_try,
   input  logic [ID_W-1:0] flit_id,
   output logic            legal,
   output logic            err
);
   pkt_state_t state_q, state_d;
   logic       err_q;
   // state register
   always_ff @(posedge clk)
      state_q <= rst ? IDLE : state_d;
   // next state: advance only on a stored flit, TAIL closes the packet
   always_comb begin
      state_d = state_q;
      if (wr_try && legal)
         state_d = (state_q == IDLE) ? IN_PKT : ((flit_id == TAIL) ? IDLE : IN_PKT);
   end
   // legality of the offered flit in the current state
   always_comb
      legal = (state_q == IDLE) ? (flit_id == HEADER) : (flit_id == PAYLOAD || flit_id == TAIL);
   // error pulse one cycle after a rejected non-full write
   always_ff @(posedge clk)
      err_q <= !rst && wr_try && !legal;
   assign err = err_q;
endmodule

// File: rtl/lbdr_input_fifo.sv
// lbdr_input_fifo: show-ahead per-port flit FIFO feeding LBDR, with credit return; packet framing check under LBDR_FIFO_PKT_CHECK_EN
module lbdr_input_fifo
   import lbdr_pkg::*;
#(
   parameter int FLIT_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [FLIT_W-1:0] wr_flit,
   input  logic              rd_en,
   output logic [FLIT_W-1:0] flit_out,
   output logic [ID_W-1:0]   flit_id,
   output logic [ADDR_W-1:0] dst_addr,
   output logic              empty,
   output logic              full,
   output logic              credit_out,
   output logic              ovf,
   output logic              err
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              credit_q, ovf_q;
   logic              wr_try, wr_acc, rd_pop, legal;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
   assign wr_try   = !rst && wr_en && !full;
   assign wr_acc   = wr_try && legal;
   assign rd_pop   = !rst && rd_en && !empty;
   assign flit_out = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign flit_id  = flit_out[FLIT_W-1 -: ID_W];
   assign dst_addr = flit_out[ADDR_W-1:0];
   assign credit_out = credit_q;
   assign ovf        = ovf_q;
`ifdef LBDR_FIFO_PKT_CHECK_EN
   lbdr_pkt_checker u_chk (
      .clk     (clk),
      .rst     (rst),
      .wr_try  (wr_try),
      .flit_id (wr_flit[FLIT_W-1 -: ID_W]),
      .legal   (legal),
      .err     (err)
   );
`else
   assign legal = 1'b1;
   assign err   = 1'b0;
`endif
   // pointer advance; the extra MSB distinguishes full from empty
   always_comb begin
      wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end
   // pointer and pulse registers; reset discards contents by collapsing the pointers
   always_ff @(posedge clk) begin
      wr_ptr_q <= rst ? '0 : wr_ptr_d;
      rd_ptr_q <= rst ? '0 : rd_ptr_d;
      credit_q <= rd_pop;
      ovf_q    <= !rst && wr_en && full;
   end
   // flit storage, intentionally not cleared by reset
   always_ff @(posedge clk)
      if (wr_acc) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_flit;
endmodule

// File: tb/tb_lbdr_input_fifo.sv
// tb_lbdr_input_fifo: directed plan plus random traffic checked by a queue-based reference model and negedge monitor
module tb_lbdr_input_fifo;
   import lbdr_pkg::*;
   localparam int DEPTH = 4;
   logic        clk = 0, rst = 1, wr_en = 0, rd_en = 0;
   logic [31:0] wr_flit = '0;
   logic [31:0] flit_out;
   logic [2:0]  flit_id;
   logic [3:0]  dst_addr;
   logic        empty, full, credit_out, ovf, err;
   int          n_chk = 0, n_fail = 0;
   int          dut_cred = 0, mod_cred = 0;
   logic [31:0] mq[$];
   bit          armed = 0, e_credit = 0, e_ovf = 0, e_err = 0;
   bit          pop, room, ok;
`ifdef LBDR_FIFO_PKT_CHECK_EN
   bit          in_pkt = 0;
`endif

   lbdr_input_fifo #(.FLIT_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_flit(wr_flit), .rd_en(rd_en),
      .flit_out(flit_out), .flit_id(flit_id), .dst_addr(dst_addr),
      .empty(empty), .full(full), .credit_out(credit_out), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] id, input logic [3:0] addr);
      logic [24:0] mid = 25'($urandom);
      return {id, mid, addr};
   endfunction

   // monitor: compare DUT outputs with the model mid-cycle, then advance the model by this cycle's inputs
   always @(negedge clk) begin
      if (armed) begin
         chk("empty", empty, mq.size() == 0);
         chk("full", full, mq.size() == DEPTH);
         chk("credit_out", credit_out, e_credit);
         chk("ovf", ovf, e_ovf);
         chk("err", err, e_err);
         if (credit_out) dut_cred++;
         if (e_credit) mod_cred++;
         if (mq.size() != 0) begin
            chk("head_flit", flit_out, mq[0]);
            chk("flit_id", flit_id, mq[0][31:29]);
            chk("dst_addr", dst_addr, mq[0][3:0]);
         end
      end
      armed = 1;
      if (rst) begin
         mq.delete();
         e_credit = 0; e_ovf = 0; e_err = 0;
`ifdef LBDR_FIFO_PKT_CHECK_EN
         in_pkt = 0;
`endif
      end else begin
         pop  = rd_en && mq.size() > 0;
         room = mq.size() < DEPTH;
         ok   = 1;
`ifdef LBDR_FIFO_PKT_CHECK_EN
         if (wr_en && room) begin
            if (!in_pkt && wr_flit[31:29] == HEADER) in_pkt = 1;
            else if (in_pkt && wr_flit[31:29] == PAYLOAD) in_pkt = 1;
            else if (in_pkt && wr_flit[31:29] == TAIL) in_pkt = 0;
            else ok = 0;
         end
`endif
         e_ovf    = wr_en && !room;
         e_err    = wr_en && room && !ok;
         e_credit = pop;
         if (pop) void'(mq.pop_front());
         if (wr_en && room && ok) mq.push_back(wr_flit);
      end
   end

   task automatic cyc(input bit r, input bit w, input bit rd, input logic [31:0] f);
      rst = r; wr_en = w; rd_en = rd; wr_flit = f;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
   endtask

   initial begin
      logic [2:0] ids [4];
      cyc(1, 0, 0, '0);
      cyc(1, 0, 0, '0);
      idle(1);
      // header reaches head one cycle after acceptance
      cyc(0, 1, 0, mk(HEADER, 4'hA));
      idle(1);
      cyc(0, 0, 1, '0);
      cyc(1, 0, 0, '0);
      // fill to full, overflow attempt, drain in order
      cyc(0, 1, 0, mk(HEADER, 4'h3));
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, mk(PAYLOAD, 4'(i)));
      cyc(0, 1, 0, mk(TAIL, 4'h7));
      cyc(0, 1, 1, mk(TAIL, 4'h8));
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, '0);
      idle(2);
      cyc(1, 0, 0, '0);
      // steady state at occupancy 2 with pointer wrap
      cyc(0, 1, 0, mk(HEADER, 4'h5));
      cyc(0, 1, 0, mk(PAYLOAD, 4'h6));
      for (int i = 0; i < 10; i++) cyc(0, 1, 1, mk(PAYLOAD, 4'(i)));
      cyc(0, 0, 1, '0);
      cyc(0, 0, 1, '0);
      idle(1);
      cyc(1, 0, 0, '0);
      // simultaneous write and read on empty, then read on empty
      cyc(0, 1, 1, mk(HEADER, 4'hC));
      idle(1);
      cyc(0, 0, 1, '0);
      cyc(0, 0, 1, '0);
      idle(1);
      cyc(1, 0, 0, '0);
      // reset mid-operation with a write pending
      cyc(0, 1, 0, mk(HEADER, 4'h1));
      cyc(0, 1, 0, mk(PAYLOAD, 4'h2));
      cyc(0, 1, 0, mk(PAYLOAD, 4'h3));
      cyc(1, 1, 0, mk(PAYLOAD, 4'h4));
      cyc(0, 1, 0, mk(HEADER, 4'hB));
      idle(1);
      cyc(0, 0, 1, '0);
      cyc(1, 0, 0, '0);
      // packet framing sequence
      cyc(0, 1, 0, mk(PAYLOAD, 4'h1));
      cyc(0, 1, 0, mk(HEADER, 4'h2));
      cyc(0, 1, 0, mk(HEADER, 4'h3));
      cyc(0, 1, 0, mk(TAIL, 4'h4));
      idle(1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, '0);
      idle(1);
      cyc(1, 0, 0, '0);
      // random traffic with mixed legal and illegal flit_ids
      ids = '{HEADER, PAYLOAD, TAIL, 3'b000};
      for (int i = 0; i < 800; i++) begin
         logic [2:0] id = ids[$urandom_range(0, 3)];
         if (id == 3'b000) id = 3'($urandom);
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, mk(id, 4'($urandom)));
      end
      idle(3);
      chk("credit_total", dut_cred, mod_cred);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
